// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and widths for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;
    localparam int REG_W = 5;
    localparam int CNT_W = 32;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD_I,
        ST_HOLD_D
    } pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: instruction/data memory handshake and hold-buffer controls
interface pipeline_ctrl_if;
    logic imem_read, imem_resp;
    logic dmem_read, dmem_write, dmem_resp;
    logic imem_buf_load, dmem_buf_load;
    logic imem_buf_sel, dmem_buf_sel;
    modport master (
        output imem_read, dmem_read, dmem_write,
        output imem_buf_load, dmem_buf_load, imem_buf_sel, dmem_buf_sel,
        input  imem_resp, dmem_resp
    );
    modport slave (
        input  imem_read, dmem_read, dmem_write,
        input  imem_buf_load, dmem_buf_load, imem_buf_sel, dmem_buf_sel,
        output imem_resp, dmem_resp
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use hazard between the EX-stage load and the ID-stage sources
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    output logic             luh
);
    // x0 never carries a dependency, so a load to x0 needs no bubble
    always_comb luh = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer gating stage loads on imem/dmem completion
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  mem,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_pcmux_sel,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles
);
    pipe_ctrl_state_t state, state_next;
    logic dmem_needed, active, i_ok, d_ok, advance, luh;

    hazard_detect u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .luh         (luh)
    );

    // state register; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_next;

    // handshake completion, next state, requests, buffer and stage controls
    always_comb begin
        dmem_needed = mem_mem_read | mem_mem_write;
        active = state != ST_IDLE;
        i_ok = mem.imem_resp | (state == ST_HOLD_I);
        d_ok = ~dmem_needed | mem.dmem_resp | (state == ST_HOLD_D);
        advance = active & i_ok & d_ok;
        state_next = (!active || advance) ? ST_WAIT :
                     (state == ST_WAIT && mem.imem_resp) ? ST_HOLD_I :
                     (state == ST_WAIT && mem.dmem_resp && dmem_needed) ? ST_HOLD_D : state;
        mem.imem_read = state == ST_WAIT || state == ST_HOLD_D;
        mem.dmem_read = mem_mem_read & (state == ST_WAIT || state == ST_HOLD_I);
        mem.dmem_write = mem_mem_write & (state == ST_WAIT || state == ST_HOLD_I);
        mem.imem_buf_load = active & mem.imem_resp & ~advance;
        mem.dmem_buf_load = active & mem.dmem_resp & ~advance;
        mem.imem_buf_sel = state == ST_HOLD_I;
        mem.dmem_buf_sel = state == ST_HOLD_D;
        id_ex_load = advance;
        ex_mem_load = advance;
        mem_wb_load = advance;
        pc_load = advance & (ex_pcmux_sel | ~luh);
        if_id_load = advance & (ex_pcmux_sel | ~luh);
        if_id_flush = advance & ex_pcmux_sel;
        id_ex_flush = advance & (ex_pcmux_sel | luh);
    end

    // saturating count of cycles in which the pipeline did not advance
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cycles <= '0;
        else if (!advance && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, corner sequences and randomized model check of pipeline_ctrl
module tb_pipeline_ctrl;
    logic clk = 0;
    logic rst = 1;
    logic mem_mem_read = 0, mem_mem_write = 0, ex_mem_read = 0, ex_pcmux_sel = 0;
    logic [4:0] ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush;
    logic [31:0] stall_cycles;
    logic [13:0] outs;
    int checks = 0, failures = 0;
    bit m_idle = 1, m_idone = 0, m_ddone = 0, m_adv = 0;
    longint m_cnt = 0;

    typedef struct {
        logic mr;
        logic [4:0] rd, rs1, rs2;
        logic br;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[8];

    pipeline_ctrl_if mif();

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .mem(mif),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_pcmux_sel(ex_pcmux_sel),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign outs = {mif.imem_read, mif.dmem_read, mif.dmem_write, pc_load, if_id_load,
                   id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush,
                   mif.imem_buf_load, mif.dmem_buf_load, mif.imem_buf_sel, mif.dmem_buf_sel};

    always @(posedge clk)
        if (!rst) assert (!(mif.imem_buf_sel && mif.imem_resp) && !(mif.dmem_buf_sel && mif.dmem_resp))
            else $error("resp for an already-completed side during hold");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // transaction-level reference: which side of the current access has completed
    task automatic sample(input string tag);
        logic [13:0] e;
        bit need, luh, iok, dok;
        @(negedge clk);
        need = mem_mem_read | mem_mem_write;
        luh = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        iok = m_idone | mif.imem_resp;
        dok = !need | m_ddone | mif.dmem_resp;
        m_adv = !m_idle && iok && dok;
        e = m_idle ? 14'd0 :
            {!m_idone, mem_mem_read & !m_ddone, mem_mem_write & !m_ddone,
             {2{m_adv & (ex_pcmux_sel | !luh)}}, {3{m_adv}},
             m_adv & ex_pcmux_sel, m_adv & (ex_pcmux_sel | luh),
             mif.imem_resp & !m_adv, mif.dmem_resp & !m_adv, m_idone, m_ddone};
        chk({tag, " outs"}, 32'(outs), 32'(e));
    endtask

    task automatic tick(input string tag);
        bit need;
        need = mem_mem_read | mem_mem_write;
        @(posedge clk);
        if (m_idle) m_idle = 0;
        else if (m_adv) begin
            m_idone = 0;
            m_ddone = 0;
        end else begin
            m_idone = m_idone | mif.imem_resp;
            m_ddone = m_ddone | (mif.dmem_resp & need);
        end
        if (!m_adv && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        #1 chk({tag, " stall"}, stall_cycles, m_cnt[31:0]);
    endtask

    task automatic cyc(input string tag);
        sample(tag);
        tick(tag);
    endtask

    initial begin
        logic [31:0] base;
        bit fresh;
        int k;
        vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 4'b0001};
        vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd3,  1'b0, 4'b1100};
        vecs[2] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b1, 4'b1111};
        vecs[3] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 4'b1100};
        vecs[4] = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 4'b0001};
        vecs[5] = '{1'b1, 5'd9,  5'd3,  5'd4,  1'b0, 4'b1100};
        vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 4'b1111};
        vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 4'b0001};
        mif.imem_resp = 1;
        mif.dmem_resp = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // zero-wait fetch: one idle bubble, then an advance every cycle
        sample("a_idle");
        chk("a_idle_outs", 32'(outs), 32'd0);
        tick("a_idle");
        chk("a_idle_cnt", stall_cycles, 32'd1);
        for (int i = 0; i < 5; i++) begin
            sample("a_run");
            chk("a_run_loads", 32'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}), 32'h1f);
            tick("a_run");
            chk("a_run_cnt", stall_cycles, 32'd1);
        end

        // hazard / branch decode table under zero-wait fetch
        for (int i = 0; i < 8; i++) begin
            ex_mem_read = vecs[i].mr;
            ex_rd = vecs[i].rd;
            id_rs1 = vecs[i].rs1;
            id_rs2 = vecs[i].rs2;
            ex_pcmux_sel = vecs[i].br;
            sample("vec");
            chk($sformatf("vec%0d", i), 32'({pc_load, if_id_load, if_id_flush, id_ex_flush}), 32'(vecs[i].exp));
            tick("vec");
        end
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; ex_pcmux_sel = 0;

        // load: imem returns first, data arrives three cycles later
        mem_mem_read = 1;
        base = stall_cycles;
        mif.imem_resp = 1;
        sample("b1");
        chk("b1_imem_buf_load", 32'(mif.imem_buf_load), 32'd1);
        tick("b1");
        mif.imem_resp = 0;
        for (int i = 2; i <= 3; i++) begin
            sample("b_hold");
            chk("b_hold_sel", 32'(mif.imem_buf_sel), 32'd1);
            chk("b_hold_noadv", 32'(ex_mem_load), 32'd0);
            tick("b_hold");
        end
        mif.dmem_resp = 1;
        sample("b4");
        chk("b4_sel", 32'(mif.imem_buf_sel), 32'd1);
        chk("b4_adv", 32'(ex_mem_load), 32'd1);
        tick("b4");
        chk("b_stall_delta", stall_cycles - base, 32'd3);
        mif.dmem_resp = 0;
        mem_mem_read = 0;

        // store: dmem returns first, imem two cycles later
        mem_mem_write = 1;
        base = stall_cycles;
        mif.dmem_resp = 1;
        sample("c1");
        chk("c1_dmem_write", 32'(mif.dmem_write), 32'd1);
        chk("c1_dmem_buf_load", 32'(mif.dmem_buf_load), 32'd1);
        tick("c1");
        mif.dmem_resp = 0;
        sample("c2");
        chk("c2_dmem_write", 32'(mif.dmem_write), 32'd0);
        chk("c2_dmem_buf_sel", 32'(mif.dmem_buf_sel), 32'd1);
        chk("c2_imem_read", 32'(mif.imem_read), 32'd1);
        tick("c2");
        mif.imem_resp = 1;
        sample("c3");
        chk("c3_adv", 32'(ex_mem_load), 32'd1);
        tick("c3");
        chk("c_stall_delta", stall_cycles - base, 32'd2);
        mif.imem_resp = 0;
        mem_mem_write = 0;

        // asynchronous reset while holding the fetched instruction
        mem_mem_read = 1;
        mif.imem_resp = 1;
        cyc("d1");
        mif.imem_resp = 0;
        @(negedge clk);
        chk("d_in_hold", 32'(mif.imem_buf_sel), 32'd1);
        #2 rst = 1;
        m_idle = 1; m_idone = 0; m_ddone = 0; m_cnt = 0;
        #1;
        chk("d_rst_outs", 32'(outs), 32'd0);
        chk("d_rst_cnt", stall_cycles, 32'd0);
        mem_mem_read = 0;
        @(posedge clk);
        #1 rst = 0;
        sample("d_idle");
        chk("d_idle_outs", 32'(outs), 32'd0);
        tick("d_idle");
        sample("d_wait");
        chk("d_wait_req", 32'(mif.imem_read), 32'd1);

        // saturation: preload near the top and stall on an unanswered load
        mem_mem_read = 1;
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles;
        m_cnt = 64'hFFFF_FFFE;
        tick("e0");
        for (int i = 0; i < 3; i++) cyc("e_sat");
        chk("e_sat_hold", stall_cycles, 32'hFFFF_FFFF);
        mif.imem_resp = 1;
        mif.dmem_resp = 1;
        cyc("e_adv");
        mif.imem_resp = 0;
        mif.dmem_resp = 0;
        mem_mem_read = 0;

        // randomized traffic against the reference model
        mif.imem_resp = 1;
        m_cnt = stall_cycles;
        fresh = 1;
        for (int i = 0; i < 600; i++) begin
            if (fresh) begin
                k = $urandom_range(0, 3);
                mem_mem_read = k == 1;
                mem_mem_write = k == 2;
            end
            mif.imem_resp = !m_idone && $urandom_range(0, 2) != 0;
            mif.dmem_resp = (mem_mem_read | mem_mem_write) && !m_ddone && $urandom_range(0, 2) != 0;
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_pcmux_sel = $urandom_range(0, 4) == 0;
            cyc("rnd");
            fresh = m_adv;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage rv32i pipeline. It generates the load enables for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB stage registers, plus the IF_ID/ID_EX flush (bubble) controls. It sequences the instruction- and data-memory request/response handshakes so that the whole pipeline advances only when every outstanding access has completed. It also inserts load-use bubbles, squashes wrong-path instructions on taken branches, and counts stall cycles.

## Interface
- (no parameters; widths fixed: register index 5 bits, counter 32 bits)
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- imem_resp  in  1  instruction memory access complete (one-cycle pulse)
- dmem_resp  in  1  data memory access complete (one-cycle pulse)
- mem_mem_read  in  1  instruction in MEM stage is a load
- mem_mem_write  in  1  instruction in MEM stage is a store
- ex_mem_read  in  1  instruction in EX stage is a load
- ex_rd  in  5  destination register of EX-stage instruction
- id_rs1, id_rs2  in  5 each  source registers of ID-stage instruction
- ex_pcmux_sel  in  1  EX-stage branch/jump taken
- imem_read  out  1  instruction fetch request
- dmem_read, dmem_write  out  1 each  data access request
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  stage register load enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP/zero control word into that register on this advance
- imem_buf_load, dmem_buf_load  out  1 each  capture early-returning rdata into the external hold buffers
- imem_buf_sel, dmem_buf_sel  out  1 each  1 = the stage consumes rdata from its hold buffer
- stall_cycles  out  32  saturating count of non-advance cycles

## Operation
- FSM states:
  - ST_IDLE: one cycle after reset, no requests issued.
  - ST_WAIT: waiting on imem, plus dmem if needed.
  - ST_HOLD_I: imem done, dmem pending.
  - ST_HOLD_D: dmem done, imem pending.
- dmem_needed = mem_mem_read | mem_mem_write.
- Requests:
  - imem_read = 1 in ST_WAIT and ST_HOLD_D.
  - dmem_read = mem_mem_read and dmem_write = mem_mem_write, in ST_WAIT and ST_HOLD_I.
  - All requests are 0 in ST_IDLE.
  - A request is held high until its resp arrives. Requests are never withdrawn mid-access.
- i_ok = imem_resp | (state==ST_HOLD_I); d_ok = ~dmem_needed | dmem_resp | (state==ST_HOLD_D).
- advance = i_ok & d_ok, evaluated in ST_WAIT/ST_HOLD_I/ST_HOLD_D only.
- Transitions:
  - ST_IDLE to ST_WAIT, unconditionally.
  - ST_WAIT to ST_WAIT on advance.
  - ST_WAIT to ST_HOLD_I when imem_resp & ~d_ok.
  - ST_WAIT to ST_HOLD_D when dmem_resp & ~imem_resp & dmem_needed.
  - ST_HOLD_I/ST_HOLD_D to ST_WAIT on advance.
- Buffers:
  - imem_buf_load = imem_resp & ~advance.
  - dmem_buf_load = dmem_resp & ~advance.
  - imem_buf_sel = (state==ST_HOLD_I).
  - dmem_buf_sel = (state==ST_HOLD_D).
- On advance:
  - ex_mem_load = mem_wb_load = id_ex_load = 1.
  - Load-use hazard: luh = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - If luh: pc_load=0, if_id_load=0, id_ex_flush=1. Otherwise pc_load=if_id_load=1.
  - If ex_pcmux_sel: pc_load=1, if_id_load=1, if_id_flush=1, id_ex_flush=1. Branch overrides luh, since the stalled instruction is wrong-path.
- Without advance, all loads and flushes are 0.
- stall_cycles increments every non-advance cycle, including ST_IDLE, and saturates at 0xFFFF_FFFF.

## Timing
- Reset (async, mid-access included):
  - State goes to ST_IDLE.
  - All outputs 0, stall_cycles=0.
  - Outstanding accesses are abandoned; memory must tolerate a dropped request.
- Loads, flushes and buf controls are combinational from the current state and inputs; they take effect on the same clk edge.
- Zero-wait memory (resp in the request cycle) gives one advance per cycle; the only bubble is ST_IDLE after reset.
- Simultaneous imem_resp & dmem_resp in ST_WAIT: advance, no buffering.
- The resp for an already-satisfied side in ST_HOLD_* is illegal; the bench asserts it never occurs.

## Structure
- FSM state enum pipe_ctrl_state_t belongs in rv32i_types.
- Sub-module hazard_detect: combinational luh computation, reused by the forwarding unit.
- Expected size of the rest: about 150-250 lines.

## Test plan
- Reset, then imem_resp tied 1 and no loads/stores:
  - Cycle 0 is ST_IDLE with stall_cycles=1.
  - Every later cycle all five loads = 1.
  - stall_cycles stays at 1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, advance:
  - pc_load=0, if_id_load=0, id_ex_flush=1.
  - ex_rd=0 with id_rs1=0 gives no bubble.
- Taken branch concurrent with luh:
  - if_id_flush=1, id_ex_flush=1, pc_load=1.
- dmem load, imem_resp at cycle 1 and dmem_resp at cycle 4:
  - imem_buf_load=1 at cycle 1.
  - ST_HOLD_I for cycles 2-4, with imem_buf_sel=1.
  - Advance at cycle 4, stall_cycles +3.
- Store, dmem_resp at cycle 1 and imem_resp at cycle 3:
  - ST_HOLD_D.
  - dmem_write drops after cycle 1.
  - dmem_buf_load=1 at cycle 1.
  - Advance at cycle 3.
- Assert rst in ST_HOLD_I:
  - Outputs go 0 immediately, before any clk edge.
  - stall_cycles=0.
  - State is ST_IDLE after release.
  - Preload stall_cycles to 0xFFFF_FFFE and stall 3 cycles: it holds at 0xFFFF_FFFF.
